// File: rtl/tag_lookup_array_pkg.sv
// Shared cache parameters: default geometry and flush FSM state encodings.
package tag_lookup_array_pkg;
  localparam int TAG_WIDTH_DEF   = 24;
  localparam int INDEX_WIDTH_DEF = 3;
  localparam int NUM_WAYS_DEF    = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } flush_state_e;
endpackage

// File: rtl/tag_lookup_array_tag_way_ram.sv
// One way of the tag array: per-set tag + valid, async read, sync write, sync set clear.
module tag_way_ram
  import tag_lookup_array_pkg::*;
#(
  parameter int TAG_WIDTH   = TAG_WIDTH_DEF,
  parameter int INDEX_WIDTH = INDEX_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_we,
  input  logic [INDEX_WIDTH-1:0] i_waddr,
  input  logic [TAG_WIDTH-1:0]   i_wtag,
  input  logic                   i_clr,
  input  logic [INDEX_WIDTH-1:0] i_clr_idx,
  input  logic [INDEX_WIDTH-1:0] i_raddr,
  output logic [TAG_WIDTH-1:0]   o_rtag,
  output logic                   o_rvalid
);
  localparam int SETS = 1 << INDEX_WIDTH;

  logic [TAG_WIDTH-1:0] r_tag [SETS];
  logic [SETS-1:0]      r_valid;

  // Tags carry no reset; a line is only trusted through its valid bit.
  always_ff @(posedge clk) begin
    if (i_we) r_tag[i_waddr] <= i_wtag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      if (i_clr) r_valid[i_clr_idx] <= 1'b0;
      if (i_we)  r_valid[i_waddr]   <= 1'b1;
    end
  end

  assign o_rtag   = r_tag[i_raddr];
  assign o_rvalid = r_valid[i_raddr];
endmodule

// File: rtl/tag_lookup_array.sv
// Set-associative tag lookup with registered hit/victim result and a one-set-per-cycle flush sweep.
module tag_lookup_array
  import tag_lookup_array_pkg::*;
#(
  parameter int TAG_WIDTH   = TAG_WIDTH_DEF,
  parameter int INDEX_WIDTH = INDEX_WIDTH_DEF,
  parameter int NUM_WAYS    = NUM_WAYS_DEF,
  localparam int WAY_W      = $clog2(NUM_WAYS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [INDEX_WIDTH-1:0] req_index,
  input  logic [TAG_WIDTH-1:0]   req_tag,
  output logic                   resp_valid,
  output logic                   resp_hit,
  output logic [WAY_W-1:0]       resp_way,
  output logic [WAY_W-1:0]       resp_victim,
  input  logic                   fill_en,
  input  logic [INDEX_WIDTH-1:0] fill_index,
  input  logic [WAY_W-1:0]       fill_way,
  input  logic [TAG_WIDTH-1:0]   fill_tag,
  input  logic                   flush_req,
  output logic                   flush_busy
);
  localparam int SETS = 1 << INDEX_WIDTH;

  flush_state_e                 r_state, w_state_nxt;
  logic [INDEX_WIDTH-1:0]       r_cnt;
  logic [SETS-1:0][WAY_W-1:0]   r_ptr;

  logic                         w_acc, w_fill, w_clr;
  logic [NUM_WAYS-1:0][TAG_WIDTH-1:0] w_rtag;
  logic [NUM_WAYS-1:0]          w_rvalid;
  logic                         w_hit, w_has_inv;
  logic [WAY_W-1:0]             w_way, w_inv_way, w_victim;

  assign flush_busy = (r_state == ST_FLUSH);
  assign req_ready  = ~flush_busy;
  assign w_acc      = req_valid & req_ready;
  assign w_fill     = fill_en & ~flush_busy;
  assign w_clr      = flush_busy;

  for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
    tag_way_ram #(.TAG_WIDTH(TAG_WIDTH), .INDEX_WIDTH(INDEX_WIDTH)) u_ram (
      .clk      (clk),
      .rst      (rst),
      .i_we     (w_fill && (fill_way == WAY_W'(g))),
      .i_waddr  (fill_index),
      .i_wtag   (fill_tag),
      .i_clr    (w_clr),
      .i_clr_idx(r_cnt),
      .i_raddr  (req_index),
      .o_rtag   (w_rtag[g]),
      .o_rvalid (w_rvalid[g])
    );
  end

  // Walk high to low so the lowest matching / lowest invalid way wins.
  always_comb begin
    w_hit     = 1'b0;
    w_way     = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (w_rvalid[w] && (w_rtag[w] == req_tag)) begin
        w_hit = 1'b1;
        w_way = WAY_W'(w);
      end
      if (!w_rvalid[w]) begin
        w_has_inv = 1'b1;
        w_inv_way = WAY_W'(w);
      end
    end
    w_victim = w_has_inv ? w_inv_way : r_ptr[req_index];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_way    <= '0;
      resp_victim <= '0;
    end else begin
      resp_valid <= w_acc;
      if (w_acc) begin
        resp_hit    <= w_hit;
        resp_way    <= w_way;
        resp_victim <= w_victim;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_clr) begin
      r_ptr[r_cnt] <= '0;
    end else if (w_fill) begin
      r_ptr[fill_index] <= fill_way + WAY_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (r_state == ST_FLUSH) ? r_cnt + INDEX_WIDTH'(1) : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (flush_req) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (&r_cnt)    w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_tag_lookup_array.sv
// Randomized + directed bench for tag_lookup_array against an array/loop reference model.
module tb_tag_lookup_array;
  localparam int SETS = 8;
  localparam int WAYS = 4;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, resp_valid, resp_hit;
  logic [2:0]  req_index, fill_index;
  logic [23:0] req_tag, fill_tag;
  logic [1:0]  resp_way, resp_victim, fill_way;
  logic        fill_en, flush_req, flush_busy;

  tag_lookup_array dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_index(req_index), .req_tag(req_tag), .resp_valid(resp_valid),
    .resp_hit(resp_hit), .resp_way(resp_way), .resp_victim(resp_victim),
    .fill_en(fill_en), .fill_index(fill_index), .fill_way(fill_way),
    .fill_tag(fill_tag), .flush_req(flush_req), .flush_busy(flush_busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  bit          m_val [SETS][WAYS];
  logic [23:0] m_tag [SETS][WAYS];
  int          m_ptr [SETS];
  bit          m_busy;
  int          m_cnt;
  bit          e_rv, e_hit;
  int          e_way, e_vic;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        m_ptr[s] = 0;
        for (int w = 0; w < WAYS; w++) m_val[s][w] = 0;
      end
      m_busy = 0; m_cnt = 0;
      e_rv = 0; e_hit = 0; e_way = 0; e_vic = 0;
      return;
    end
    e_rv = req_valid && !m_busy;
    if (e_rv) begin
      e_hit = 0; e_way = 0;
      for (int w = 0; w < WAYS; w++)
        if (!e_hit && m_val[req_index][w] && m_tag[req_index][w] == req_tag) begin
          e_hit = 1; e_way = w;
        end
      e_vic = m_ptr[req_index];
      for (int w = WAYS - 1; w >= 0; w--)
        if (!m_val[req_index][w]) e_vic = w;
    end
    if (fill_en && !m_busy) begin
      m_val[fill_index][fill_way] = 1;
      m_tag[fill_index][fill_way] = fill_tag;
      m_ptr[fill_index] = (int'(fill_way) + 1) % WAYS;
    end
    if (m_busy) begin
      for (int w = 0; w < WAYS; w++) m_val[m_cnt][w] = 0;
      m_ptr[m_cnt] = 0;
      if (m_cnt == SETS - 1) m_busy = 0;
      else m_cnt++;
    end else if (flush_req) begin
      m_busy = 1; m_cnt = 0;
    end
  endtask

  // One clock: advance model, take the edge, compare every output.
  task automatic cyc();
    model_step();
    @(posedge clk); #1;
    chk("flush_busy", flush_busy, m_busy);
    chk("req_ready", req_ready, !m_busy);
    chk("resp_valid", resp_valid, e_rv);
    chk("resp_hit", resp_hit, e_hit);
    chk("resp_way", resp_way, e_way);
    chk("resp_victim", resp_victim, e_vic);
  endtask

  task automatic idle();
    req_valid = 0; fill_en = 0; flush_req = 0; rst = 0;
  endtask

  task automatic look(input int idx, input int tag);
    idle(); req_valid = 1; req_index = 3'(idx); req_tag = 24'(tag); cyc();
  endtask

  task automatic fill(input int idx, input int way, input int tag);
    idle(); fill_en = 1; fill_index = 3'(idx); fill_way = 2'(way); fill_tag = 24'(tag); cyc();
  endtask

  int busy_cycles;

  initial begin
    idle(); rst = 1;
    req_index = 0; req_tag = 0; fill_index = 0; fill_way = 0; fill_tag = 0;
    cyc();
    idle();
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_hit", resp_hit, 0);
    chk("rst_victim", resp_victim, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", flush_busy, 0);

    look(3, 'hABCDEF);
    chk("l1_valid", resp_valid, 1);
    chk("l1_hit", resp_hit, 0);
    chk("l1_victim", resp_victim, 0);
    idle(); cyc();
    chk("l1_pulse", resp_valid, 0);
    chk("l1_hold_hit", resp_hit, 0);

    fill(3, 2, 'h123456);
    look(3, 'h123456);
    chk("l2_hit", resp_hit, 1);
    chk("l2_way", resp_way, 2);
    chk("l2_victim", resp_victim, 0);

    for (int w = 0; w < WAYS; w++) fill(5, w, 'h500 + w);
    look(5, 'hFFF);
    chk("l3_hit", resp_hit, 0);
    chk("l3_victim_wrap", resp_victim, 0);
    fill(5, 0, 'h555);
    look(5, 'hFFF);
    chk("l3_victim_rr", resp_victim, 1);
    look(5, 'h502);
    chk("l3_hit_way", resp_way, 2);

    idle(); fill_en = 1; fill_index = 1; fill_way = 0; fill_tag = 'h77;
    req_valid = 1; req_index = 1; req_tag = 'h77; cyc();
    chk("rbw_miss", resp_hit, 0);
    look(1, 'h77);
    chk("rbw_hit", resp_hit, 1);

    idle(); flush_req = 1; cyc();
    flush_req = 0; req_valid = 1; req_index = 3; req_tag = 'h123456;
    busy_cycles = 0;
    while (flush_busy && busy_cycles < 20) begin
      busy_cycles++;
      chk("flush_ready_low", req_ready, 0);
      cyc();
    end
    chk("flush_len", busy_cycles, 8);
    look(3, 'h123456); chk("post_flush_3", resp_hit, 0);
    look(5, 'h502);    chk("post_flush_5", resp_hit, 0);
    look(1, 'h77);     chk("post_flush_1", resp_hit, 0);
    chk("post_flush_vic", resp_victim, 0);

    fill(2, 3, 'h42); fill(6, 1, 'h66);
    idle(); flush_req = 1; cyc();
    idle(); cyc(); cyc(); cyc();
    rst = 1; flush_req = 1; fill_en = 1; cyc();
    idle();
    chk("abort_busy", flush_busy, 0);
    look(2, 'h42); chk("abort_2", resp_hit, 0); chk("abort_vic2", resp_victim, 0);
    look(6, 'h66); chk("abort_6", resp_hit, 0); chk("abort_vic6", resp_victim, 0);

    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 299) == 0);
      flush_req  = ($urandom_range(0, 79) == 0);
      req_valid  = $urandom_range(0, 1) == 1;
      req_index  = 3'($urandom_range(0, 7));
      req_tag    = 24'($urandom_range(0, 3));
      fill_en    = $urandom_range(0, 2) == 0;
      fill_index = 3'($urandom_range(0, 7));
      fill_way   = 2'($urandom_range(0, 3));
      fill_tag   = 24'($urandom_range(0, 3));
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
